hamming_serial_encoder: RTL

//  Upstream stage of the serial Hamming(15,11) decoder. Accepts an 11-bit data word

---
 rtl/hamming_pkg.sv | 44 ++++
 rtl/hamming_serial_encoder_if.sv | 21 ++
 rtl/hamming_parity_gen.sv | 28 ++
 rtl/hamming_serial_encoder.sv | 108 ++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(15,11) definitions used by the serial encoder and decoder:
// sizes, position/data-index mapping and parity cover masks.
package hamming_pkg;

   localparam int unsigned PARITY_BITS = 4;
   localparam int unsigned CODE_W      = (1 << PARITY_BITS) - 1;
   localparam int unsigned DATA_W      = CODE_W - PARITY_BITS;
   localparam int unsigned CNT_W       = $clog2(CODE_W);
   localparam int unsigned DIDX_W      = $clog2(DATA_W);

   // Bit p-1 of a codeword_t holds codeword position p.
   typedef logic [CODE_W-1:0] codeword_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } enc_state_e;

   function automatic logic is_parity_pos(input int unsigned pos);
      return ((pos & (pos - 1)) == 0);
   endfunction

   // Data index carried at a non-parity position (d1 -> 0 ... d11 -> 10).
   function automatic int unsigned pos_to_data_idx(input int unsigned pos);
      int unsigned n;
      n = 0;
      for (int unsigned p = 1; p < pos; p++) begin
         if (!is_parity_pos(p)) n++;
      end
      return n;
   endfunction

   // Positions whose index has bit i set; parity bit 2^i covers these.
   function automatic codeword_t cover_mask(input int unsigned i);
      codeword_t m;
      m = '0;
      for (int unsigned p = 1; p <= CODE_W; p++) begin
         if (((p >> i) & 1) != 0) m[CNT_W'(p - 1)] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/hamming_serial_encoder_if.sv
// Word-in / serial-bit-out bus between the data source and the Hamming encoder.
interface hamming_serial_encoder_if;
   import hamming_pkg::*;

   logic [DATA_W-1:0] data_in;
   logic              in_valid;
   logic              in_ready;
   logic              dout;
   logic              dout_valid;
   logic              done;

   modport master (
      output data_in, in_valid,
      input  in_ready, dout, dout_valid, done
   );

   modport slave (
      input  data_in, in_valid,
      output in_ready, dout, dout_valid, done
   );
endinterface

// File: rtl/hamming_parity_gen.sv
// Combinational Hamming(15,11) codeword builder: places data bits and
// computes even parity at positions 1,2,4,8.
module hamming_parity_gen
   import hamming_pkg::*;
(
   input  data_t     data,
   output codeword_t codeword
);

   codeword_t placed;

   always_comb begin
      placed = '0;
      for (int unsigned pos = 1; pos <= CODE_W; pos++) begin
         if (!is_parity_pos(pos))
            placed[CNT_W'(pos - 1)] = data[DIDX_W'(pos_to_data_idx(pos))];
      end
   end

   // Parity positions are zero in placed, so each mask only sees data bits.
   always_comb begin
      codeword = placed;
      for (int unsigned i = 0; i < PARITY_BITS; i++) begin
         codeword[CNT_W'((1 << i) - 1)] = ^(placed & cover_mask(i));
      end
   end

endmodule

// File: rtl/hamming_serial_encoder.sv
// Serial Hamming(15,11) encoder: accepts an 11-bit word on valid/ready and
// shifts the codeword out position 1 first, back-to-back with no idle gap.
module hamming_serial_encoder
   import hamming_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   hamming_serial_encoder_if.slave   bus
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CODE_W - 1);

   enc_state_e       state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   codeword_t        sreg_q, sreg_d;
   logic             dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             done_q, done_d;
   logic             in_ready_q, in_ready_d;

   codeword_t        codeword;
   logic             accept;

   hamming_parity_gen u_parity_gen (
      .data     (bus.data_in),
      .codeword (codeword)
   );

   assign accept = bus.in_valid && in_ready_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         sreg_q       <= '0;
         dout_q       <= 1'b0;
         dout_valid_q <= 1'b0;
         done_q       <= 1'b0;
         in_ready_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         sreg_q       <= sreg_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         done_q       <= done_d;
         in_ready_q   <= in_ready_d;
      end
   end

   // Next-state and next-output logic; outputs are the registered values above.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      sreg_d       = sreg_q;
      dout_d       = 1'b0;
      dout_valid_d = 1'b0;
      done_d       = 1'b0;
      in_ready_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            in_ready_d = 1'b1;
            if (accept) begin
               state_d      = ST_SHIFT;
               bit_cnt_d    = '0;
               sreg_d       = codeword >> 1;
               dout_d       = codeword[0];
               dout_valid_d = 1'b1;
               in_ready_d   = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (bit_cnt_q == LAST_CNT) begin
               if (accept) begin
                  bit_cnt_d    = '0;
                  sreg_d       = codeword >> 1;
                  dout_d       = codeword[0];
                  dout_valid_d = 1'b1;
               end else begin
                  state_d    = ST_IDLE;
                  bit_cnt_d  = '0;
                  sreg_d     = '0;
                  in_ready_d = 1'b1;
               end
            end else begin
               bit_cnt_d    = bit_cnt_q + CNT_W'(1);
               sreg_d       = sreg_q >> 1;
               dout_d       = sreg_q[0];
               dout_valid_d = 1'b1;
               done_d       = ((bit_cnt_q + CNT_W'(1)) == LAST_CNT);
               in_ready_d   = ((bit_cnt_q + CNT_W'(1)) == LAST_CNT);
            end
         end
         default: begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sreg_d    = '0;
         end
      endcase
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.done       = done_q;

endmodule
